// File: rtl/mmio_user_io.sv
// mmio_user_io: memory-mapped user I/O and performance counters (CPU window 0x8000_00xx).
//
// Ports
//   clk, rst_n       CPU clock (rising edge) and asynchronous active-low reset
//   addr             byte offset into the window; addr[1:0] ignored
//   rd_en / wr_en    one-cycle load / store strobes (never both high)
//   wdata            store data
//   rdata            registered load data, valid the cycle after rd_en, held until the next rd_en
//   inst_retire      one pulse per retired instruction
//   clean_buttons    debounced, already-synchronous buttons; rising edges push events into a FIFO
//   switches         raw switches, synchronised here through two flops
//   leds             LED register
//
// Word map (addr[7:2]):
//   0x10 cycle count (R)   0x14 instruction count (R)   0x18 clear both counters (W)
//   0x1C freeze bit0 (R/W) 0x20 FIFO empty (R)          0x24 pop FIFO head (R)
//   0x28 FIFO count (R)    0x2C sticky overflow (R, W clears)
//   0x30 switches (R)      0x34 leds (R/W)
module mmio_user_io #(
    parameter int unsigned N_BUTTONS  = 3,
    parameter int unsigned N_SWITCHES = 2,
    parameter int unsigned N_LEDS     = 6,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            addr,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic                  inst_retire,
    input  logic [N_BUTTONS-1:0]  clean_buttons,
    input  logic [N_SWITCHES-1:0] switches,
    output logic [N_LEDS-1:0]     leds
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [5:0] AddrCycle  = 6'h04;
    localparam logic [5:0] AddrInst   = 6'h05;
    localparam logic [5:0] AddrClear  = 6'h06;
    localparam logic [5:0] AddrFreeze = 6'h07;
    localparam logic [5:0] AddrEmpty  = 6'h08;
    localparam logic [5:0] AddrPop    = 6'h09;
    localparam logic [5:0] AddrCount  = 6'h0A;
    localparam logic [5:0] AddrOvf    = 6'h0B;
    localparam logic [5:0] AddrSwitch = 6'h0C;
    localparam logic [5:0] AddrLeds   = 6'h0D;

    logic [5:0] word;
    assign word = addr[7:2];

    logic [CNT_W-1:0]      cyc_q, cyc_d;
    logic [CNT_W-1:0]      ins_q, ins_d;
    logic                  freeze_q, freeze_d;
    logic                  ovf_q, ovf_d;
    logic [N_LEDS-1:0]     leds_q, leds_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [N_BUTTONS-1:0]  prev_q;
    logic [N_SWITCHES-1:0] sw_meta_q, sw_sync_q;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [N_BUTTONS-1:0]  mem_q [FIFO_DEPTH];

    logic [PW-1:0]        count;
    logic                 empty, full;
    logic [N_BUTTONS-1:0] rise;
    logic                 push_req, pop, push, drop;
    logic                 wr_clear, wr_freeze, wr_ovf, wr_leds;
    logic [31:0]          rd_val;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign count = wptr_q - rptr_q;
    assign empty = (count == '0);
    assign full  = (count == PW'(FIFO_DEPTH));

    assign rise     = clean_buttons & ~prev_q;
    assign push_req = |rise;
    assign pop      = rd_en && (word == AddrPop) && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign wr_clear  = wr_en && (word == AddrClear);
    assign wr_freeze = wr_en && (word == AddrFreeze);
    assign wr_ovf    = wr_en && (word == AddrOvf);
    assign wr_leds   = wr_en && (word == AddrLeds);

    always_comb begin
        rd_val = '0;
        case (word)
            AddrCycle:  rd_val = 32'(cyc_q);
            AddrInst:   rd_val = 32'(ins_q);
            AddrFreeze: rd_val = {31'd0, freeze_q};
            AddrEmpty:  rd_val = {31'd0, empty};
            AddrPop:    rd_val = empty ? 32'd0 : 32'(mem_q[rptr_q[AW-1:0]]);
            AddrCount:  rd_val = 32'(count);
            AddrOvf:    rd_val = {31'd0, ovf_q};
            AddrSwitch: rd_val = 32'(sw_sync_q);
            AddrLeds:   rd_val = 32'(leds_q);
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        cyc_d    = cyc_q;
        ins_d    = ins_q;
        freeze_d = freeze_q;
        ovf_d    = ovf_q;
        leds_d   = leds_q;
        rdata_d  = rdata_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;

        // Clear beats increment; freeze only takes effect from the following edge.
        if (wr_clear) begin
            cyc_d = '0;
            ins_d = '0;
        end else if (!freeze_q) begin
            cyc_d = cyc_q + CNT_W'(1);
            ins_d = ins_q + CNT_W'(inst_retire);
        end

        if (wr_freeze) freeze_d = wdata[0];
        if (wr_leds)   leds_d   = wdata[N_LEDS-1:0];

        // A dropped event in the same cycle as a clear keeps the flag set.
        if (drop)        ovf_d = 1'b1;
        else if (wr_ovf) ovf_d = 1'b0;

        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);

        if (rd_en) rdata_d = rd_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q     <= '0;
            ins_q     <= '0;
            freeze_q  <= 1'b0;
            ovf_q     <= 1'b0;
            leds_q    <= '0;
            rdata_q   <= '0;
            prev_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
            freeze_q  <= freeze_d;
            ovf_q     <= ovf_d;
            leds_q    <= leds_d;
            rdata_q   <= rdata_d;
            prev_q    <= clean_buttons;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= clean_buttons;
    end

    assign rdata = rdata_q;
    assign leds  = leds_q;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

endmodule

// File: tb/tb_mmio_user_io.sv
// Self-checking bench for mmio_user_io with default parameters.
module tb_mmio_user_io;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        inst_retire = 1'b0;
    logic [2:0]  cb = '0;
    logic [1:0]  sw = '0;
    logic [5:0]  leds;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_user_io dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .rd_en         (rd_en),
        .wr_en         (wr_en),
        .wdata         (wdata),
        .rdata         (rdata),
        .inst_retire   (inst_retire),
        .clean_buttons (cb),
        .switches      (sw),
        .leds          (leds)
    );

    // Reference model state
    int unsigned m_cyc, m_ins;
    bit          m_freeze, m_ovf;
    logic [2:0]  m_prev;
    logic [2:0]  m_fifo [$];
    logic [5:0]  m_leds;
    logic [31:0] m_rdata;
    logic [1:0]  m_sw1, m_sw2;

    task automatic model_reset();
        m_cyc = 0; m_ins = 0; m_freeze = 0; m_ovf = 0; m_prev = '0;
        m_fifo.delete(); m_leds = '0; m_rdata = '0; m_sw1 = '0; m_sw2 = '0;
    endtask

    // Apply the current inputs to the model, then let the DUT take the same edge.
    task automatic tick();
        logic [31:0] val;
        logic [2:0]  rise;
        val = '0;
        if (rd_en) begin
            case (addr[7:2])
                6'h04: val = m_cyc;
                6'h05: val = m_ins;
                6'h07: val = {31'd0, m_freeze};
                6'h08: val = (m_fifo.size() == 0) ? 32'd1 : 32'd0;
                6'h09: if (m_fifo.size() > 0) val = {29'd0, m_fifo.pop_front()};
                6'h0A: val = m_fifo.size();
                6'h0B: val = {31'd0, m_ovf};
                6'h0C: val = {30'd0, m_sw2};
                6'h0D: val = {26'd0, m_leds};
                default: val = '0;
            endcase
            m_rdata = val;
        end
        if (wr_en && addr[7:2] == 6'h0B) m_ovf = 0;
        rise = cb & ~m_prev;
        if (rise != 0) begin
            if (m_fifo.size() < 8) m_fifo.push_back(cb);
            else m_ovf = 1;
        end
        if (wr_en && addr[7:2] == 6'h06) begin
            m_cyc = 0;
            m_ins = 0;
        end else if (!m_freeze) begin
            m_cyc++;
            if (inst_retire) m_ins++;
        end
        if (wr_en && addr[7:2] == 6'h07) m_freeze = wdata[0];
        if (wr_en && addr[7:2] == 6'h0D) m_leds = wdata[5:0];
        m_sw2 = m_sw1;
        m_sw1 = sw;
        m_prev = cb;
        @(negedge clk);
    endtask

    task automatic idle();
        rd_en = 0; wr_en = 0; inst_retire = 0;
        tick();
    endtask

    task automatic bus_read(input logic [7:0] a);
        wr_en = 0; rd_en = 1; addr = a;
        tick();
        rd_en = 0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        rd_en = 0; wr_en = 1; addr = a; wdata = d;
        tick();
        wr_en = 0;
    endtask

    task automatic press(input logic [2:0] v);
        cb = v; idle();
        cb = '0; idle();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (rdata !== 32'd0) begin
            failures++; $display("FAIL reset_rdata: got %0h want 0", rdata);
        end
        checks++;
        if (leds !== 6'd0) begin
            failures++; $display("FAIL reset_leds: got %0h want 0", leds);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        model_reset();
        bus_read(8'h20);
        checks++;
        if (rdata !== 32'd1) begin
            failures++; $display("FAIL reset_empty: got %0h want 1", rdata);
        end
        bus_read(8'h28);
        checks++;
        if (rdata !== 32'd0) begin
            failures++; $display("FAIL reset_count: got %0h want 0", rdata);
        end
    endtask

    task automatic test_counters();
        repeat (23) idle();
        bus_read(8'h10);
        checks++;
        if (rdata !== m_rdata) begin
            failures++; $display("FAIL cycle_count: got %0d want %0d", rdata, m_rdata);
        end
        for (int i = 0; i < 10; i++) begin
            inst_retire = 1; tick(); inst_retire = 0;
            repeat ($urandom_range(0, 3)) idle();
        end
        bus_read(8'h14);
        checks++;
        if (rdata !== 32'd10) begin
            failures++; $display("FAIL inst_count: got %0d want 10", rdata);
        end
    endtask

    task automatic test_clear_freeze();
        logic [31:0] frozen;
        inst_retire = 1; wr_en = 1; addr = 8'h18; wdata = $urandom;
        tick();
        inst_retire = 0; wr_en = 0;
        bus_read(8'h10);
        checks++;
        if (rdata !== 32'd0) begin
            failures++; $display("FAIL clear_cycle: got %0d want 0", rdata);
        end
        bus_read(8'h14);
        checks++;
        if (rdata !== 32'd0) begin
            failures++; $display("FAIL clear_inst: got %0d want 0", rdata);
        end
        bus_write(8'h1C, 32'd1);
        bus_read(8'h10);
        frozen = m_rdata;
        for (int i = 0; i < 50; i++) begin
            inst_retire = 1'($urandom_range(0, 1));
            tick();
        end
        inst_retire = 0;
        bus_read(8'h10);
        checks++;
        if (rdata !== frozen) begin
            failures++; $display("FAIL freeze_cycle: got %0d want %0d", rdata, frozen);
        end
        bus_read(8'h14);
        checks++;
        if (rdata !== m_rdata) begin
            failures++; $display("FAIL freeze_inst: got %0d want %0d", rdata, m_rdata);
        end
        bus_read(8'h1C);
        checks++;
        if (rdata !== 32'd1) begin
            failures++; $display("FAIL freeze_bit: got %0d want 1", rdata);
        end
        bus_write(8'h1C, 32'd0);
    endtask

    task automatic test_fifo_basic();
        bus_read(8'h20);
        checks++;
        if (rdata !== 32'd1) begin
            failures++; $display("FAIL fifo_empty0: got %0d want 1", rdata);
        end
        cb = 3'b111;
        bus_read(8'h20);
        bus_read(8'h20);
        checks++;
        if (rdata !== 32'd0) begin
            failures++; $display("FAIL fifo_nonempty: got %0d want 0", rdata);
        end
        bus_read(8'h28);
        checks++;
        if (rdata !== 32'd1) begin
            failures++; $display("FAIL fifo_count1: got %0d want 1", rdata);
        end
        bus_read(8'h24);
        checks++;
        if (rdata !== 32'd7) begin
            failures++; $display("FAIL fifo_pop7: got %0d want 7", rdata);
        end
        bus_read(8'h20);
        checks++;
        if (rdata !== 32'd1) begin
            failures++; $display("FAIL fifo_empty1: got %0d want 1", rdata);
        end
        cb = '0; idle();
    endtask

    task automatic test_fifo_overflow();
        logic [2:0] first;
        logic [2:0] v;
        while (m_fifo.size() > 0) bus_read(8'h24);
        bus_write(8'h2C, 32'd0);
        first = 3'($urandom_range(1, 7));
        press(first);
        for (int i = 1; i < 10; i++) begin
            v = 3'($urandom_range(1, 7));
            press(v);
        end
        bus_read(8'h28);
        checks++;
        if (rdata !== 32'd8) begin
            failures++; $display("FAIL ovf_count: got %0d want 8", rdata);
        end
        bus_read(8'h2C);
        checks++;
        if (rdata !== 32'd1) begin
            failures++; $display("FAIL ovf_flag: got %0d want 1", rdata);
        end
        bus_read(8'h24);
        checks++;
        if (rdata !== {29'd0, first}) begin
            failures++; $display("FAIL ovf_first_pop: got %0d want %0d", rdata, first);
        end
        bus_write(8'h2C, $urandom);
        bus_read(8'h2C);
        checks++;
        if (rdata !== 32'd0) begin
            failures++; $display("FAIL ovf_clear: got %0d want 0", rdata);
        end
        press(3'b010);
        // Push and pop together while full
        cb = 3'b101; rd_en = 1; addr = 8'h24;
        tick();
        rd_en = 0;
        checks++;
        if (rdata !== m_rdata) begin
            failures++; $display("FAIL full_pushpop_data: got %0d want %0d", rdata, m_rdata);
        end
        bus_read(8'h28);
        checks++;
        if (rdata !== 32'd8) begin
            failures++; $display("FAIL full_pushpop_count: got %0d want 8", rdata);
        end
        bus_read(8'h2C);
        checks++;
        if (rdata !== 32'd0) begin
            failures++; $display("FAIL full_pushpop_ovf: got %0d want 0", rdata);
        end
        cb = '0; idle();
    endtask

    task automatic test_switches_leds();
        sw = 2'b11;
        repeat (3) bus_read(8'h30);
        checks++;
        if (rdata !== 32'd3) begin
            failures++; $display("FAIL switches: got %0d want 3", rdata);
        end
        bus_write(8'h34, 32'h11);
        checks++;
        if (leds !== 6'b010001) begin
            failures++; $display("FAIL leds_pins: got %b want 010001", leds);
        end
        bus_read(8'h34);
        checks++;
        if (rdata !== 32'h11) begin
            failures++; $display("FAIL leds_read: got %0h want 11", rdata);
        end
    endtask

    task automatic test_random();
        int unsigned op;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 9) < 3) cb = 3'($urandom);
            if ($urandom_range(0, 19) == 0) sw = 2'($urandom);
            inst_retire = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {2'b00, 4'($urandom), 2'($urandom)};
            wdata = $urandom;
            rd_en = (op < 5);
            wr_en = (op >= 5 && op < 7);
            tick();
            checks++;
            if (rdata !== m_rdata) begin
                failures++;
                $display("FAIL rand_rdata[%0d]: got %0h want %0h", i, rdata, m_rdata);
            end
            checks++;
            if (leds !== m_leds) begin
                failures++; $display("FAIL rand_leds[%0d]: got %0h want %0h", i, leds, m_leds);
            end
        end
        rd_en = 0; wr_en = 0; inst_retire = 0; cb = '0;
        idle();
        bus_write(8'h1C, 32'd0);
    endtask

    task automatic test_reset_mid();
        bus_write(8'h34, 32'h3F);
        press(3'b001);
        cb = 3'b110;
        rd_en = 1; addr = 8'h10;
        #2 rst_n = 0;
        #1;
        checks++;
        if (rdata !== 32'd0) begin
            failures++; $display("FAIL midreset_rdata: got %0h want 0", rdata);
        end
        checks++;
        if (leds !== 6'd0) begin
            failures++; $display("FAIL midreset_leds: got %0h want 0", leds);
        end
        rd_en = 0; cb = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        model_reset();
        bus_read(8'h20);
        checks++;
        if (rdata !== 32'd1) begin
            failures++; $display("FAIL midreset_empty: got %0d want 1", rdata);
        end
        bus_read(8'h10);
        checks++;
        if (rdata !== m_rdata) begin
            failures++; $display("FAIL midreset_cycle: got %0d want %0d", rdata, m_rdata);
        end
        bus_read(8'h14);
        checks++;
        if (rdata !== 32'd0) begin
            failures++; $display("FAIL midreset_inst: got %0d want 0", rdata);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_counters();
        test_clear_freeze();
        test_fifo_basic();
        test_fifo_overflow();
        test_switches_leds();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
